// File: rtl/sseg_scan_controller.sv
// Four-digit seven-segment scan controller: hex display of raw nibbles, or
// decimal display through a sequential double-dabble engine with blanking/overflow.
module sseg_scan_controller #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        WE,
    input  logic        MODE,
    output logic        BUSY,
    output logic [7:0]  CATHODES,
    output logic [3:0]  ANODES
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_LOAD    = 2'd2;

    // Glyph codes 0-15 are hex digits; two extra codes for dash and blank
    localparam logic [4:0] G_DASH  = 5'd16;
    localparam logic [4:0] G_BLANK = 5'd17;

    logic [1:0]       r_state;
    logic [15:0]      r_shift;
    logic [19:0]      r_bcd;
    logic [3:0]       r_iter;
    logic [3:0][4:0]  r_glyph;
    logic [CW-1:0]    r_scanCnt;
    logic [1:0]       r_index;
    logic [7:0]       r_cathodes;
    logic [3:0]       r_anodes;

    logic [19:0]      w_bcdAdj;
    logic [19:0]      w_bcdNext;
    logic [3:0][4:0]  w_decGlyph;
    logic [7:0]       w_segment;

    always_comb begin
        w_bcdAdj = r_bcd;
        for (int d = 0; d < 5; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcdAdj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_bcdNext = {w_bcdAdj[18:0], r_shift[15]};

    // A nonzero ten-thousands digit means the value exceeds 9999
    always_comb begin
        w_decGlyph = {4{G_BLANK}};
        if (r_bcd[19:16] != 4'd0) begin
            w_decGlyph = {4{G_DASH}};
        end else begin
            for (int d = 0; d < 4; d++) begin
                w_decGlyph[d] = {1'b0, r_bcd[4*d +: 4]};
            end
            if (r_bcd[15:12] == 4'd0) begin
                w_decGlyph[3] = G_BLANK;
                if (r_bcd[11:8] == 4'd0) begin
                    w_decGlyph[2] = G_BLANK;
                    if (r_bcd[7:4] == 4'd0) begin
                        w_decGlyph[1] = G_BLANK;
                    end
                end
            end
        end
    end

    // Any write restarts: decimal reloads the converter, hex aborts it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_glyph <= '0;
        end else if (WE) begin
            if (MODE) begin
                r_state <= S_CONVERT;
                r_shift <= DATA;
                r_bcd   <= '0;
                r_iter  <= '0;
            end else begin
                r_state <= S_IDLE;
                r_glyph <= {1'b0, DATA[15:12], 1'b0, DATA[11:8],
                            1'b0, DATA[7:4],   1'b0, DATA[3:0]};
            end
        end else begin
            case (r_state)
                S_CONVERT: begin
                    r_shift <= {r_shift[14:0], 1'b0};
                    r_bcd   <= w_bcdNext;
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_glyph <= w_decGlyph;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_glyph[r_index])
            5'd0:    w_segment = 8'hC0;
            5'd1:    w_segment = 8'hF9;
            5'd2:    w_segment = 8'hA4;
            5'd3:    w_segment = 8'hB0;
            5'd4:    w_segment = 8'h99;
            5'd5:    w_segment = 8'h92;
            5'd6:    w_segment = 8'h82;
            5'd7:    w_segment = 8'hF8;
            5'd8:    w_segment = 8'h80;
            5'd9:    w_segment = 8'h90;
            5'd10:   w_segment = 8'h88;
            5'd11:   w_segment = 8'h83;
            5'd12:   w_segment = 8'hC6;
            5'd13:   w_segment = 8'hA1;
            5'd14:   w_segment = 8'h86;
            5'd15:   w_segment = 8'h8E;
            G_DASH:  w_segment = 8'hBF;
            default: w_segment = 8'hFF;
        endcase
    end

    // The scan runs freely; writes never disturb it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_scanCnt  <= '0;
            r_index    <= '0;
            r_anodes   <= 4'b1110;
            r_cathodes <= 8'hC0;
        end else begin
            if (r_scanCnt == SCAN_LAST) begin
                r_scanCnt <= '0;
                r_index   <= r_index + 2'd1;
            end else begin
                r_scanCnt <= r_scanCnt + CW'(1);
            end
            r_anodes   <= ~(4'b0001 << r_index);
            r_cathodes <= w_segment;
        end
    end

    assign BUSY     = (r_state != S_IDLE);
    assign CATHODES = r_cathodes;
    assign ANODES   = r_anodes;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Randomised scoreboard bench for sseg_scan_controller; expected displays come
// from an arithmetic reference model and are checked by an independent monitor.
module tb_sseg_scan_controller;
    localparam int SCAN   = 4;
    localparam int SCAN_B = 1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        we;
    logic        mode;
    logic [15:0] data;
    logic        busy;
    logic [7:0]  cathodes;
    logic [3:0]  anodes;

    logic        resetB;
    logic        busyB;
    logic [7:0]  cathodesB;
    logic [3:0]  anodesB;

    int          testsRun  = 0;
    int          failCount = 0;
    logic [31:0] expQ[$];
    logic [31:0] prevExp;
    string       curLabel = "reset";
    bit          periodDone = 1'b0;

    always #5 clock = ~clock;

    sseg_scan_controller #(.SCAN_DIV(SCAN)) dut (
        .CLK(clock), .RST(reset), .DATA(data), .WE(we), .MODE(mode),
        .BUSY(busy), .CATHODES(cathodes), .ANODES(anodes)
    );

    sseg_scan_controller #(.SCAN_DIV(SCAN_B)) dutB (
        .CLK(clock), .RST(resetB), .DATA(16'h0000), .WE(1'b0), .MODE(1'b0),
        .BUSY(busyB), .CATHODES(cathodesB), .ANODES(anodesB)
    );

    function automatic logic [7:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Reference: {digit3,digit2,digit1,digit0} cathode bytes for a write
    function automatic logic [31:0] refDisplay(input logic m, input logic [15:0] v);
        logic [31:0] r;
        int pw[4];
        int n;
        pw = '{1, 10, 100, 1000};
        n = int'(v);
        r = '0;
        for (int d = 0; d < 4; d++) begin
            if (!m)                     r[8*d +: 8] = hexSeg(v[4*d +: 4]);
            else if (n > 9999)          r[8*d +: 8] = 8'hBF;
            else if (d == 0 || n >= pw[d]) r[8*d +: 8] = hexSeg(4'((n / pw[d]) % 10));
            else                        r[8*d +: 8] = 8'hFF;
        end
        return r;
    endfunction

    function automatic int anodeIndex(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [15:0] v);
        we   = 1'b1;
        mode = m;
        data = v;
        @(negedge clock);
        we   = 1'b0;
    endtask

    task automatic waitBusyLow(output int cnt, input bit doHold, input logic [31:0] holdExp);
        int g = 0;
        int bad = 0;
        int idx;
        cnt = 0;
        while (busy && g < 100) begin
            cnt++;
            if (doHold) begin
                idx = anodeIndex(anodes);
                if (idx < 0 || cathodes != holdExp[8*idx +: 8]) bad++;
            end
            @(negedge clock);
            g++;
        end
        if (doHold) checkOutput({curLabel, " hold old display"}, bad, 0);
    endtask

    task automatic waitDrained();
        int g = 0;
        while (expQ.size() != 0 && g < 200) begin
            @(negedge clock);
            g++;
        end
        checkOutput({curLabel, " scoreboard drained"}, expQ.size(), 0);
    endtask

    task automatic runDecimal(input string label, input logic [15:0] v);
        int cnt;
        curLabel = label;
        applyStimulus(1'b1, v);
        waitBusyLow(cnt, 1'b1, prevExp);
        checkOutput({label, " busy cycles"}, cnt, 17);
        prevExp = refDisplay(1'b1, v);
        expQ.push_back(prevExp);
        waitDrained();
    endtask

    task automatic runHex(input string label, input logic [15:0] v);
        curLabel = label;
        applyStimulus(1'b0, v);
        checkOutput({label, " busy after hex"}, busy, 1'b0);
        prevExp = refDisplay(1'b0, v);
        expQ.push_back(prevExp);
        waitDrained();
    endtask

    // Monitor: for each expected display, watch a full scan and compare every digit
    initial begin : scoreboardMonitor
        logic [31:0] exp;
        logic [7:0]  got[4];
        bit          seen[4];
        int          idx;
        forever begin
            while (expQ.size() == 0) @(negedge clock);
            exp = expQ[0];
            repeat (2) @(negedge clock);
            for (int d = 0; d < 4; d++) begin
                seen[d] = 1'b0;
                got[d]  = 8'h00;
            end
            for (int c = 0; c < 4 * SCAN + 2; c++) begin
                @(negedge clock);
                idx = anodeIndex(anodes);
                if (idx >= 0) begin
                    got[idx]  = cathodes;
                    seen[idx] = 1'b1;
                end
            end
            for (int d = 0; d < 4; d++) begin
                checkOutput($sformatf("%s digit%0d", curLabel, d),
                            seen[d] ? {24'h0, got[d]} : 32'hFFFF_FFFF, {24'h0, exp[8*d +: 8]});
            end
            void'(expQ.pop_front());
        end
    end

    // Slower instance: the digit slot must last exactly SCAN_DIV cycles
    initial begin : periodCheck
        int cyc = 0;
        int changes = 0;
        int firstChange = 0;
        int lastChange = 0;
        logic [3:0] prevAn;
        resetB = 1'b1;
        repeat (2) @(negedge clock);
        resetB = 1'b0;
        prevAn = anodesB;
        while (changes < 2 && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (anodesB != prevAn) begin
                changes++;
                if (changes == 1) firstChange = cyc;
                else lastChange = cyc;
                prevAn = anodesB;
            end
        end
        checkOutput("anode period", (changes == 2) ? lastChange - firstChange : -1, SCAN_B);
        checkOutput("anode after two slots", {28'h0, prevAn}, {28'h0, 4'b1011});
        periodDone = 1'b1;
    end

    initial begin : mainStimulus
        logic [3:0]  seq[4];
        int          times[4];
        logic [3:0]  expSeq[4];
        logic [3:0]  prevAn;
        int          changes;
        int          g;
        int          cnt;
        logic        m;
        logic [15:0] v;

        expSeq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        reset = 1'b1;
        we    = 1'b0;
        mode  = 1'b0;
        data  = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset anodes", {28'h0, anodes}, {28'h0, 4'b1110});
        checkOutput("reset cathodes", {24'h0, cathodes}, 32'hC0);
        checkOutput("reset busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;

        changes = 0;
        g = 0;
        prevAn = anodes;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 4'h0;
            times[i] = 0;
        end
        while (changes < 4 && g < 50) begin
            @(negedge clock);
            g++;
            if (anodes != prevAn) begin
                seq[changes]   = anodes;
                times[changes] = g;
                changes++;
                prevAn = anodes;
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("scan order %0d", i), {28'h0, seq[i]}, {28'h0, expSeq[i]});
        end
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("scan slot %0d length", i), times[i] - times[i-1], SCAN);
        end
        prevExp = 32'hC0C0C0C0;
        expQ.push_back(prevExp);
        waitDrained();

        runHex("hex A3F0", 16'hA3F0);
        runDecimal("dec 1234", 16'd1234);
        runDecimal("dec 7", 16'd7);
        runDecimal("dec 0", 16'd0);
        runDecimal("dec 10000", 16'd10000);
        runDecimal("dec 65535", 16'd65535);
        runDecimal("dec 9999", 16'd9999);

        // Decimal restart: second write five cycles after the first
        curLabel = "restart";
        applyStimulus(1'b1, 16'd1234);
        cnt = 0;
        repeat (4) begin
            if (busy) cnt++;
            @(negedge clock);
        end
        if (busy) cnt++;
        applyStimulus(1'b1, 16'd56);
        begin
            int rest;
            waitBusyLow(rest, 1'b1, prevExp);
            cnt += rest;
        end
        checkOutput("restart busy cycles", cnt, 22);
        prevExp = refDisplay(1'b1, 16'd56);
        expQ.push_back(prevExp);
        waitDrained();

        // Hex write aborts a running conversion
        curLabel = "hex abort";
        applyStimulus(1'b1, 16'd1234);
        repeat (3) @(negedge clock);
        applyStimulus(1'b0, 16'h5E1C);
        checkOutput("hex abort busy", {31'h0, busy}, 32'h0);
        prevExp = refDisplay(1'b0, 16'h5E1C);
        expQ.push_back(prevExp);
        waitDrained();
        repeat (20) @(negedge clock);
        checkOutput("hex abort busy later", {31'h0, busy}, 32'h0);
        curLabel = "hex abort later";
        expQ.push_back(prevExp);
        waitDrained();

        for (int i = 0; i < 10; i++) begin
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom_range(0, 9));
                1:       v = 16'($urandom_range(0, 9999));
                2:       v = 16'($urandom_range(10000, 65535));
                default: v = 16'($urandom);
            endcase
            if (m) runDecimal($sformatf("rand%0d dec %0d", i, v), v);
            else   runHex($sformatf("rand%0d hex %0h", i, v), v);
        end

        // Reset on the eighth conversion cycle discards the pending value
        curLabel = "reset mid-conversion";
        applyStimulus(1'b1, 16'd4321);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset mid busy", {31'h0, busy}, 32'h0);
        repeat (25) @(negedge clock);
        checkOutput("reset mid busy later", {31'h0, busy}, 32'h0);
        prevExp = 32'hC0C0C0C0;
        expQ.push_back(prevExp);
        waitDrained();

        g = 0;
        while (!periodDone && g < 6000) begin
            @(negedge clock);
            g++;
        end
        checkOutput("period check finished", {31'h0, periodDone}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
